dmux8way16_dispatch: RTL and testbench
======================================

// Module: dmux8way16_dispatch
// PURPOSE
//  Registered 8-way, 16-bit demultiplexer with valid/ready flow control: the write-side
//  counterpart of the 8-way 16-bit selector. One input stream carries a word plus a 3-bit
//  destination select; each word is delivered to exactly one of 8 output channels.
//  Each channel holds one word until its consumer takes it.
//  Sits between a single producer (CPU/bus side) and 8 independent word sinks.
// PARAMETERS
//  WIDTH  16  data word width in bits
//  WAYS    8  number of output channels (power of two, >= 2)
//  SEL_W   3  select width, = $clog2(WAYS)
// PORTS
//  clk        in   1            single clock; all state on rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  in_valid   in   1            input word/select present
//  in_ready   out  1            block accepts input this cycle
//  in_data    in   WIDTH        input word
//  in_sel     in   SEL_W        destination channel index
//  out_valid  out  WAYS         bit i: channel i holds a word
//  out_ready  in   WAYS         bit i: consumer i takes word this cycle
//  out_data   out  WAYS*WIDTH   channel i word at [i*WIDTH +: WIDTH]
//  busy       out  1            OR of out_valid
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): all full_q[i]=0, data_q[i]=0, so
//    out_valid=0, out_data=0, busy=0. Reset mid-operation discards every buffered word.
//  - Per-channel 1-entry slot: full_q[i], data_q[i]. out_valid[i]=full_q[i], out_data[i]=data_q[i].
//  - Drain: out_valid[i] & out_ready[i] -> word i consumed at that edge.
//  - in_ready = !full_q[in_sel] | out_ready[in_sel] (combinational; pass-through on same-cycle drain).
//  - Accept: in_valid & in_ready -> data_q[in_sel]<=in_data, full_q[in_sel]<=1 next edge.
//  - Latency: accepted word visible on out_valid/out_data exactly 1 cycle after accept.
//  - Same-cycle drain+refill of channel i: full_q[i] stays 1, data_q[i] takes new word.
//  - Drain of channel j while accept to channel i!=j: both apply independently.
//  - out_ready[i] with full_q[i]=0: ignored. Non-selected channels never change on accept.
//  - Producer must hold in_data/in_sel stable while in_valid & !in_ready; block still
//    recomputes in_ready from current in_sel every cycle (no internal latch of sel).
//  - No reordering within a channel; no ordering guarantee across channels.
//  - All 2^SEL_W select values are legal; no error path.
// CONFIGURATION
//  DMUX_COUNT_EN defined: adds ports
//    cnt_clr  in   1           synchronous clear of all counters (wins over increment)
//    cnt      out  WAYS*16     per-channel delivered-word count, [i*16 +: 16]
//    counter i +1 on each drain of channel i, wraps 16'hFFFF -> 0, resets to 0.
//  DMUX_COUNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package gates_pkg: WIDTH/WAYS/SEL_W constants, typedef word_t [WIDTH-1:0],
//    typedef sel_t [SEL_W-1:0].
//  - Sub-module dmux_slot: one channel (full/data regs, load, drain, optional counter);
//    top instantiates WAYS copies via generate plus the in_ready select/decode.
// TESTING
//  1. Reset: rst_n=0 mid-traffic -> out_valid=8'h00, out_data=0, busy=0, in_ready=1 immediately.
//  2. Single send: in_data=16'hBEEF, in_sel=5, out_ready=0 -> next cycle out_valid=8'h20,
//     channel 5 data=16'hBEEF; other channels unchanged.
//  3. Backpressure: ch 2 full, out_ready[2]=0, in_sel=2 -> in_ready=0, data_q[2] unchanged;
//     raise out_ready[2] -> same-cycle accept, ch 2 holds new word, out_valid[2] stays 1.
//  4. Parallel: ch 0 draining while word 16'h1234 sent to ch 7 -> out_valid[0]=0,
//     out_valid[7]=1 next cycle.
//  5. Sweep: send i*16'h1111 to sel=i for i=0..7, no drain -> out_valid=8'hFF, busy=1,
//     every in_ready=0; drain all -> out_valid=0.
//  6. DMUX_COUNT_EN: 3 drains on ch 4 -> cnt[4]=3; preload 16'hFFFF + 1 drain -> 0;
//     cnt_clr with drain same cycle -> 0.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared constants and word/select types for the 8-way 16-bit dispatch block.
// The optional per-channel delivery counters are enabled with DMUX_COUNT_EN.
package gates_pkg;
  localparam int WIDTH = 16;
  localparam int WAYS  = 8;
  localparam int SEL_W = $clog2(WAYS);
  localparam int CNT_W = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/dmux8way16_dispatch_if.sv
// Producer/consumer bus of the 8-way dispatcher: one input stream, eight output slots.
interface dmux8way16_dispatch_if;
  import gates_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  word_t                   in_data;
  sel_t                    in_sel;
  logic [WAYS-1:0]         out_valid;
  logic [WAYS-1:0]         out_ready;
  logic [WAYS*WIDTH-1:0]   out_data;
  logic                    busy;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/dmux8way16_dispatch_slot.sv
// One output channel: a single-entry word buffer with load/drain and, when
// DMUX_COUNT_EN is defined, a wrapping count of words delivered.
module dmux_slot
  import gates_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t din,
  input  logic  drain_rdy,
`ifdef DMUX_COUNT_EN
  input  logic  cnt_clr,
  output cnt_t  cnt,
`endif
  output logic  full,
  output word_t dout
);

  logic  full_q;
  word_t data_q;
  logic  drain;

  assign drain = full_q & drain_rdy;
  assign full  = full_q;
  assign dout  = data_q;

  // Load wins over drain so a same-cycle drain+refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= din;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

`ifdef DMUX_COUNT_EN
  cnt_t cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/dmux8way16_dispatch.sv
// Registered 8-way 16-bit demultiplexer with valid/ready on both sides.
// Define DMUX_COUNT_EN to add cnt_clr/cnt per-channel delivery counters.
module dmux8way16_dispatch
  import gates_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DMUX_COUNT_EN
  input  logic                  cnt_clr,
  output logic [WAYS*CNT_W-1:0] cnt,
`endif
  dmux8way16_dispatch_if.slave  bus
);

  logic  full_arr [WAYS];
  word_t data_arr [WAYS];
  logic  [WAYS-1:0] load;
  logic  accept;
`ifdef DMUX_COUNT_EN
  cnt_t  cnt_arr  [WAYS];
`endif

  // Ready is decided from the currently addressed slot only; a draining slot
  // can take the next word in the same cycle.
  assign bus.in_ready = !full_arr[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < WAYS; i++) begin
      load[i] = accept & (bus.in_sel == sel_t'(i));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_slot
    dmux_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .din       (bus.in_data),
      .drain_rdy (bus.out_ready[g]),
`ifdef DMUX_COUNT_EN
      .cnt_clr   (cnt_clr),
      .cnt       (cnt_arr[g]),
`endif
      .full      (full_arr[g]),
      .dout      (data_arr[g])
    );
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int i = 0; i < WAYS; i++) begin
      bus.out_valid[i]                = full_arr[i];
      bus.out_data[i*WIDTH +: WIDTH]  = data_arr[i];
    end
  end

  assign bus.busy = |bus.out_valid;

`ifdef DMUX_COUNT_EN
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      cnt[i*CNT_W +: CNT_W] = cnt_arr[i];
    end
  end
`endif

endmodule

// File: tb/tb_dmux8way16_dispatch.sv
// Self-checking bench for dmux8way16_dispatch: directed scenarios plus random
// traffic compared every cycle against a per-channel slot model.
module tb_dmux8way16_dispatch;
  import gates_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmux8way16_dispatch_if ifc();

`ifdef DMUX_COUNT_EN
  logic                  cnt_clr = 1'b0;
  logic [WAYS*CNT_W-1:0] cnt;
`endif

  dmux8way16_dispatch dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef DMUX_COUNT_EN
    .cnt_clr (cnt_clr),
    .cnt     (cnt),
`endif
    .bus     (ifc)
  );

  // Reference: each channel is a one-word mailbox.
  bit          m_full [WAYS];
  logic [15:0] m_data [WAYS];
  int unsigned m_cnt  [WAYS];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    for (int i = 0; i < WAYS; i++) v[i] = m_full[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < WAYS; i++) begin
      m_full[i] = 0;
      m_data[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  // Apply one clock edge of behaviour to the model using the current inputs.
  task automatic m_edge();
    bit    take;
    bit    drained [WAYS];
    int    s;
    s    = int'(ifc.in_sel);
    take = ifc.in_valid && (!m_full[s] || ifc.out_ready[s]);
    for (int i = 0; i < WAYS; i++) drained[i] = m_full[i] && ifc.out_ready[i];
    for (int i = 0; i < WAYS; i++) begin
      if (take && s == i) begin
        m_full[i] = 1;
        m_data[i] = ifc.in_data;
      end else if (drained[i]) begin
        m_full[i] = 0;
      end
`ifdef DMUX_COUNT_EN
      if (cnt_clr) m_cnt[i] = 0;
      else if (drained[i]) m_cnt[i] = (m_cnt[i] + 1) % 65536;
`endif
    end
  endtask

  task automatic compare_all();
    int s;
    s = int'(ifc.in_sel);
    chk("in_ready", 32'(ifc.in_ready), 32'(!m_full[s] || ifc.out_ready[s]));
    chk("out_valid", 32'(ifc.out_valid), 32'(m_valid()));
    chk("busy", 32'(ifc.busy), 32'(m_valid() != 0));
    for (int i = 0; i < WAYS; i++)
      chk("out_data", 32'(ifc.out_data[i*16 +: 16]), 32'(m_data[i]));
`ifdef DMUX_COUNT_EN
    for (int i = 0; i < WAYS; i++)
      chk("cnt", 32'(cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
  endtask

  // Called at a negedge: drive, compare mid-cycle, take the edge, return at next negedge.
  task automatic step(input bit v, input logic [15:0] d, input logic [2:0] s, input logic [7:0] ordy);
    ifc.in_valid  = v;
    ifc.in_data   = d;
    ifc.in_sel    = s;
    ifc.out_ready = ordy;
    #1 compare_all();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_sel    = '0;
    ifc.out_ready = '0;
    m_reset();
    #1;
    chk("rst_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_busy", 32'(ifc.busy), 32'h0);
    chk("rst_ready", 32'(ifc.in_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single send
    step(1, 16'hBEEF, 3'd5, 8'h00);
    #1;
    chk("single_valid", 32'(ifc.out_valid), 32'h20);
    chk("single_data", 32'(ifc.out_data[5*16 +: 16]), 32'hBEEF);
    chk("single_other", 32'(ifc.out_data[4*16 +: 16]), 32'h0);
    step(0, 16'h0, 3'd0, 8'h20);

    // Backpressure and same-cycle refill
    step(1, 16'hAAAA, 3'd2, 8'h00);
    ifc.in_valid = 1'b1; ifc.in_data = 16'h5555; ifc.in_sel = 3'd2; ifc.out_ready = 8'h00;
    #1 chk("bp_ready", 32'(ifc.in_ready), 32'h0);
    step(1, 16'h5555, 3'd2, 8'h00);
    chk("bp_hold", 32'(ifc.out_data[2*16 +: 16]), 32'hAAAA);
    step(1, 16'h5555, 3'd2, 8'h04);
    chk("refill_valid", 32'(ifc.out_valid[2]), 32'h1);
    chk("refill_data", 32'(ifc.out_data[2*16 +: 16]), 32'h5555);
    step(0, 16'h0, 3'd0, 8'h04);

    // Parallel drain of ch 0 with send to ch 7
    step(1, 16'h0F0F, 3'd0, 8'h00);
    step(1, 16'h1234, 3'd7, 8'h01);
    chk("par_v0", 32'(ifc.out_valid[0]), 32'h0);
    chk("par_v7", 32'(ifc.out_valid[7]), 32'h1);
    chk("par_d7", 32'(ifc.out_data[7*16 +: 16]), 32'h1234);
    step(0, 16'h0, 3'd0, 8'hFF);

    // Sweep fill of every channel
    for (int i = 0; i < WAYS; i++) step(1, 16'(i * 16'h1111), 3'(i), 8'h00);
    chk("sweep_valid", 32'(ifc.out_valid), 32'hFF);
    chk("sweep_busy", 32'(ifc.busy), 32'h1);
    chk("sweep_d6", 32'(ifc.out_data[6*16 +: 16]), 32'h6666);
    for (int i = 0; i < WAYS; i++) begin
      ifc.in_valid = 1'b1; ifc.in_sel = 3'(i); ifc.out_ready = 8'h00;
      #1 chk("sweep_ready", 32'(ifc.in_ready), 32'h0);
    end
    step(0, 16'h0, 3'd0, 8'hFF);
    chk("sweep_drain", 32'(ifc.out_valid), 32'h0);

`ifdef DMUX_COUNT_EN
    cnt_clr = 1'b1;
    step(0, 16'h0, 3'd0, 8'h00);
    cnt_clr = 1'b0;
    step(1, 16'h4444, 3'd4, 8'h00);
    step(1, 16'h4445, 3'd4, 8'h10);
    step(1, 16'h4446, 3'd4, 8'h10);
    step(0, 16'h0, 3'd4, 8'h10);
    chk("cnt_three", 32'(cnt[4*16 +: 16]), 32'd3);
    cnt_clr = 1'b1;
    step(0, 16'h0, 3'd0, 8'h00);
    cnt_clr = 1'b0;
    step(1, 16'h0001, 3'd4, 8'h00);
    for (int k = 0; k < 65535; k++) step(1, 16'(k), 3'd4, 8'h10);
    chk("cnt_max", 32'(cnt[4*16 +: 16]), 32'hFFFF);
    step(1, 16'h0002, 3'd4, 8'h10);
    chk("cnt_wrap", 32'(cnt[4*16 +: 16]), 32'h0);
    cnt_clr = 1'b1;
    step(0, 16'h0, 3'd4, 8'h10);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", 32'(cnt[4*16 +: 16]), 32'h0);
`endif

    // Random traffic with a mid-stream reset
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom_range(0, 7)),
           8'($urandom) & 8'($urandom));
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ifc.out_valid), 32'h0);
        chk("mid_rst_data", 32'(ifc.out_data[31:0]) | 32'(ifc.out_data[127:96]), 32'h0);
        chk("mid_rst_busy", 32'(ifc.busy), 32'h0);
        chk("mid_rst_ready", 32'(ifc.in_ready), 32'h1);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
